// File: rtl/moviment_controller_if.sv
// Request/status bundle between a floor-request source and moviment_controller.
interface moviment_controller_if #(
  parameter int unsigned FLOOR_W = 2
);
  logic               req_valid;
  logic [FLOOR_W-1:0] req_target;
  logic               req_ready;
  logic               stop;
  logic [FLOOR_W-1:0] floor;
  logic               direction;
  logic               moving;
  logic               door_open;
  logic               arrived;
  logic               req_err;

  modport master (
    output req_valid, req_target, stop,
    input  req_ready, floor, direction, moving, door_open, arrived, req_err
  );

  modport slave (
    input  req_valid, req_target, stop,
    output req_ready, floor, direction, moving, door_open, arrived, req_err
  );
endinterface

// File: rtl/moviment_controller.sv
// Single-car movement controller: accepts one target floor at a time while idle,
// travels floor by floor with a per-floor timer, then holds the door open.
module moviment_controller #(
  parameter int unsigned FLOORS        = 4,
  parameter int unsigned FLOOR_W       = $clog2(FLOORS),
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  moviment_controller_if.slave  bus
);

  localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    LP_TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]    LP_DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0] LP_FLOORS      = (FLOOR_W + 1)'(FLOORS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_DOOR
  } state_t;

  state_t             r_state;
  logic [FLOOR_W-1:0] r_floor;
  logic [FLOOR_W-1:0] r_target;
  logic [TW-1:0]      r_timer;
  logic               r_direction;
  logic               r_moving;
  logic               r_door_open;
  logic               r_arrived;
  logic               r_req_err;

  logic               w_out_of_range;
  logic [FLOOR_W-1:0] w_step_floor;

  // Extra bit so FLOORS itself is representable when FLOORS is a power of two.
  assign w_out_of_range = ({1'b0, bus.req_target} >= LP_FLOORS);
  assign w_step_floor   = r_direction ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_floor     <= '0;
      r_target    <= '0;
      r_timer     <= '0;
      r_direction <= 1'b1;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
      r_arrived   <= 1'b0;
      r_req_err   <= 1'b0;
    end else begin
      r_arrived <= 1'b0;
      r_req_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (w_out_of_range) begin
              r_req_err <= 1'b1;
            end else if (bus.req_target == r_floor) begin
              r_state     <= S_DOOR;
              r_timer     <= LP_DOOR_LOAD;
              r_arrived   <= 1'b1;
              r_door_open <= 1'b1;
            end else begin
              r_direction <= (bus.req_target > r_floor);
              r_target    <= bus.req_target;
              r_timer     <= LP_TRAVEL_LOAD;
              r_state     <= S_MOVING;
              r_moving    <= 1'b1;
            end
          end
        end
        S_MOVING: begin
          if (!bus.stop) begin
            if (r_timer == '0) begin
              r_floor <= w_step_floor;
              if (w_step_floor == r_target) begin
                r_state     <= S_DOOR;
                r_timer     <= LP_DOOR_LOAD;
                r_arrived   <= 1'b1;
                r_moving    <= 1'b0;
                r_door_open <= 1'b1;
              end else begin
                r_timer <= LP_TRAVEL_LOAD;
              end
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
        end
        S_DOOR: begin
          if (r_timer == '0) begin
            r_state     <= S_IDLE;
            r_door_open <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_moving    <= 1'b0;
          r_door_open <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.floor     = r_floor;
  assign bus.direction = r_direction;
  assign bus.moving    = r_moving;
  assign bus.door_open = r_door_open;
  assign bus.arrived   = r_arrived;
  assign bus.req_err   = r_req_err;

endmodule

// File: tb/tb_moviment_controller.sv
// Directed bench for moviment_controller with FLOORS=4, TRAVEL_CYCLES=3, DOOR_CYCLES=2.
module tb_moviment_controller;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // One spare bus bit so out-of-range targets such as 5 can be driven.
  moviment_controller_if #(.FLOOR_W(3)) bus ();

  moviment_controller #(
    .FLOORS(4),
    .FLOOR_W(3),
    .TRAVEL_CYCLES(3),
    .DOOR_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move_to(input logic [2:0] t);
    int n;
    bus.req_valid  = 1'b1;
    bus.req_target = t;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n >= 200 || bus.floor !== t) begin
      bad++;
      $display("FAIL move_to floor=%0d required=%0d wait=%0d", bus.floor, t, n);
    end
  endtask

  task automatic test_reset();
    bus.req_valid  = 1'b0;
    bus.req_target = '0;
    bus.stop       = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (bus.floor !== 3'd0 || bus.direction !== 1'b1 || bus.moving !== 1'b0 ||
        bus.door_open !== 1'b0 || bus.arrived !== 1'b0 || bus.req_err !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset floor=%0d dir=%b mov=%b door=%b arr=%b err=%b rdy=%b required 0 1 0 0 0 0 1",
               bus.floor, bus.direction, bus.moving, bus.door_open, bus.arrived, bus.req_err, bus.req_ready);
    end
  endtask

  task automatic test_up();
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd2;
    tick();
    bus.req_valid = 1'b0;
    total++;
    if (bus.direction !== 1'b1 || bus.moving !== 1'b1 || bus.req_ready !== 1'b0 || bus.floor !== 3'd0) begin
      bad++;
      $display("FAIL up_accept dir=%b mov=%b rdy=%b floor=%0d required 1 1 0 0",
               bus.direction, bus.moving, bus.req_ready, bus.floor);
    end
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] ef;
      logic ea, ed, em, er;
      tick();
      ef = (k < 3) ? 3'd0 : (k < 6) ? 3'd1 : 3'd2;
      ea = (k == 6);
      ed = (k == 6 || k == 7);
      em = (k <= 5);
      er = (k >= 8);
      total++;
      if (bus.floor !== ef || bus.arrived !== ea || bus.door_open !== ed ||
          bus.moving !== em || bus.req_ready !== er || bus.direction !== 1'b1) begin
        bad++;
        $display("FAIL up_edge%0d floor=%0d arr=%b door=%b mov=%b rdy=%b dir=%b required %0d %b %b %b %b 1",
                 k, bus.floor, bus.arrived, bus.door_open, bus.moving, bus.req_ready, bus.direction,
                 ef, ea, ed, em, er);
      end
    end
  endtask

  task automatic test_down();
    int arrivals;
    move_to(3'd3);
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd0;
    tick();
    bus.req_valid = 1'b0;
    total++;
    if (bus.direction !== 1'b0 || bus.moving !== 1'b1) begin
      bad++;
      $display("FAIL down_accept dir=%b mov=%b required 0 1", bus.direction, bus.moving);
    end
    arrivals = 0;
    for (int k = 1; k <= 11; k++) begin
      logic [2:0] ef;
      logic ea, ed, er;
      tick();
      ef = (k < 3) ? 3'd3 : (k < 6) ? 3'd2 : (k < 9) ? 3'd1 : 3'd0;
      ea = (k == 9);
      ed = (k == 9 || k == 10);
      er = (k >= 11);
      if (bus.arrived === 1'b1) arrivals++;
      total++;
      if (bus.floor !== ef || bus.arrived !== ea || bus.door_open !== ed ||
          bus.req_ready !== er || bus.direction !== 1'b0) begin
        bad++;
        $display("FAIL down_edge%0d floor=%0d arr=%b door=%b rdy=%b dir=%b required %0d %b %b %b 0",
                 k, bus.floor, bus.arrived, bus.door_open, bus.req_ready, bus.direction, ef, ea, ed, er);
      end
    end
    total++;
    if (arrivals != 1) begin
      bad++;
      $display("FAIL down_arrivals count=%0d required=1", arrivals);
    end
  endtask

  task automatic test_same_floor();
    move_to(3'd2);
    move_to(3'd1);
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd1;
    tick();
    bus.req_valid = 1'b0;
    total++;
    if (bus.arrived !== 1'b1 || bus.door_open !== 1'b1 || bus.moving !== 1'b0 ||
        bus.direction !== 1'b0 || bus.floor !== 3'd1 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL same_edge0 arr=%b door=%b mov=%b dir=%b floor=%0d rdy=%b required 1 1 0 0 1 0",
               bus.arrived, bus.door_open, bus.moving, bus.direction, bus.floor, bus.req_ready);
    end
    tick();
    total++;
    if (bus.arrived !== 1'b0 || bus.door_open !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL same_edge1 arr=%b door=%b rdy=%b required 0 1 0", bus.arrived, bus.door_open, bus.req_ready);
    end
    tick();
    total++;
    if (bus.door_open !== 1'b0 || bus.req_ready !== 1'b1 || bus.direction !== 1'b0) begin
      bad++;
      $display("FAIL same_edge2 door=%b rdy=%b dir=%b required 0 1 0", bus.door_open, bus.req_ready, bus.direction);
    end
  endtask

  task automatic test_err();
    logic [2:0] targets [2];
    targets[0] = 3'd5;
    targets[1] = 3'd4;
    for (int i = 0; i < 2; i++) begin
      bus.req_valid  = 1'b1;
      bus.req_target = targets[i];
      tick();
      bus.req_valid = 1'b0;
      total++;
      if (bus.req_err !== 1'b1 || bus.req_ready !== 1'b1 || bus.floor !== 3'd1 ||
          bus.direction !== 1'b0 || bus.moving !== 1'b0 || bus.door_open !== 1'b0) begin
        bad++;
        $display("FAIL err_t%0d err=%b rdy=%b floor=%0d dir=%b mov=%b door=%b required 1 1 1 0 0 0",
                 targets[i], bus.req_err, bus.req_ready, bus.floor, bus.direction, bus.moving, bus.door_open);
      end
      tick();
      total++;
      if (bus.req_err !== 1'b0 || bus.floor !== 3'd1) begin
        bad++;
        $display("FAIL err_clear_t%0d err=%b floor=%0d required 0 1", targets[i], bus.req_err, bus.floor);
      end
    end
  endtask

  task automatic test_stop();
    move_to(3'd0);
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd2;
    tick();
    // keep a different request on the bus while travelling: it must be ignored
    bus.req_target = 3'd3;
    for (int k = 1; k <= 13; k++) begin
      logic [2:0] ef;
      logic ea, ed, em, er;
      tick();
      ef = (k < 3) ? 3'd0 : (k < 11) ? 3'd1 : 3'd2;
      ea = (k == 11);
      ed = (k == 11 || k == 12);
      em = (k <= 10);
      er = (k >= 13);
      total++;
      if (bus.floor !== ef || bus.arrived !== ea || bus.door_open !== ed ||
          bus.moving !== em || bus.req_ready !== er) begin
        bad++;
        $display("FAIL stop_edge%0d floor=%0d arr=%b door=%b mov=%b rdy=%b required %0d %b %b %b %b",
                 k, bus.floor, bus.arrived, bus.door_open, bus.moving, bus.req_ready, ef, ea, ed, em, er);
      end
      if (k == 2)  bus.req_valid = 1'b0;
      if (k == 3)  bus.stop = 1'b1;
      if (k == 8)  bus.stop = 1'b0;
      if (k == 11) bus.stop = 1'b1;
      if (k == 13) bus.stop = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    move_to(3'd3);
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd0;
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (bus.floor !== 3'd2 || bus.moving !== 1'b1 || bus.direction !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pre floor=%0d mov=%b dir=%b required 2 1 0", bus.floor, bus.moving, bus.direction);
    end
    rst            = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd1;
    tick();
    total++;
    if (bus.floor !== 3'd0 || bus.req_ready !== 1'b1 || bus.direction !== 1'b1 || bus.moving !== 1'b0 ||
        bus.door_open !== 1'b0 || bus.arrived !== 1'b0 || bus.req_err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid floor=%0d rdy=%b dir=%b mov=%b door=%b arr=%b err=%b required 0 1 1 0 0 0 0",
               bus.floor, bus.req_ready, bus.direction, bus.moving, bus.door_open, bus.arrived, bus.req_err);
    end
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    total++;
    if (bus.floor !== 3'd0 || bus.req_ready !== 1'b1 || bus.moving !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_drop floor=%0d rdy=%b mov=%b required 0 1 0", bus.floor, bus.req_ready, bus.moving);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_target = '0;
    bus.stop       = 1'b0;
    test_reset();
    test_up();
    test_down();
    test_same_floor();
    test_err();
    test_stop();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/moviment_controller.md
MOVIMENT_CONTROLLER -- requirements
Module: moviment_controller

Interface
REQ-001 Parameters SHALL be, one per line:
  FLOORS, 4, number of floors served (2..16); floors numbered 0..FLOORS-1
  FLOOR_W, $clog2(FLOORS), width of floor/target buses
  TRAVEL_CYCLES, 8, clock cycles to move one floor (>=1)
  DOOR_CYCLES, 4, clock cycles the door stays open on arrival (>=1)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, all state on rising edge
  rst  input  1  synchronous, active-high reset
  req_valid  input  1  target request present
  req_target  input  FLOOR_W  requested floor
  req_ready  output  1  block accepts a request this cycle
  stop  input  1  emergency hold; freezes travel while high
  floor  output  FLOOR_W  current floor
  direction  output  1  1 = going_up, 0 = going_down
  moving  output  1  high while in MOVING
  door_open  output  1  high while in DOOR
  arrived  output  1  one-cycle pulse on reaching target
  req_err  output  1  one-cycle pulse on out-of-range request
REQ-003 Reset SHALL be synchronous and active-high on rst; single clock clk.

Function
REQ-004 FSM states SHALL be IDLE, MOVING, DOOR; exactly one active.
REQ-005 req_ready SHALL be 1 only in IDLE (combinational from state); a request is accepted on an edge where req_valid && req_ready.
REQ-006 Accepted req_target >= FLOORS: req_err pulses the next cycle; state, floor, direction unchanged.
REQ-007 Accepted req_target == floor: next state DOOR, arrived pulses the next cycle, direction unchanged.
REQ-008 Accepted req_target > floor: direction <= 1; < floor: direction <= 0; target latched; next state MOVING; travel timer <= TRAVEL_CYCLES-1.
REQ-009 In MOVING with stop low: if timer == 0, floor steps by +1 (direction 1) or -1 (direction 0) and timer reloads TRAVEL_CYCLES-1; else timer decrements.
REQ-010 In MOVING with stop high: timer and floor SHALL hold; state stays MOVING; moving stays 1.
REQ-011 On the edge where the stepped floor equals the latched target, state SHALL go to DOOR, door timer <= DOOR_CYCLES-1, and arrived pulses for exactly the following cycle.
REQ-012 In DOOR: door timer decrements each cycle; on the edge where it is 0, state goes IDLE; door_open is high exactly DOOR_CYCLES cycles.
REQ-013 req_valid in MOVING or DOOR SHALL be ignored (not queued); stop outside MOVING has no effect.
REQ-014 floor SHALL never leave 0..FLOORS-1; no wrap-around.
REQ-015 direction SHALL change only on request acceptance (REQ-008); it holds its value through DOOR and IDLE.
REQ-016 Timers SHALL be sized to hold max(TRAVEL_CYCLES, DOOR_CYCLES)-1 with no overflow.

Reset
REQ-017 On rst: state IDLE, floor 0, direction 1 (going_up), moving 0, door_open 0, arrived 0, req_err 0, timers 0, latched target 0.
REQ-018 rst SHALL take priority over every other input in any state, including mid-travel and mid-door; a request presented with rst high is dropped.

Verification
REQ-019 FLOORS=4, TRAVEL_CYCLES=3, DOOR_CYCLES=2; accept target 2 from floor 0 at edge 0 -> direction 1, floor=1 after edge 3, floor=2 after edge 6, arrived high for one cycle after edge 6, door_open high 2 cycles, IDLE after edge 8.
REQ-020 From floor 3, request target 0 -> direction 0, floor 3,2,1,0 at 3-cycle intervals, arrived once at floor 0.
REQ-021 From floor 1, request target 1 -> no motion, arrived pulse next cycle, door_open 2 cycles, direction unchanged.
REQ-022 Request target 5 with FLOORS=4 -> req_err one pulse, state IDLE, floor unchanged.
REQ-023 stop held 5 cycles mid-travel -> floor and timer frozen; arrival delayed by exactly 5 cycles versus REQ-019.
REQ-024 rst asserted mid-MOVING at floor 2 -> next cycle floor 0, IDLE, direction 1, req_ready 1, all pulses 0.
